// File: rtl/tdm_accum_pkg.sv
// Shared constants and helpers for the TDM accumulator.
// Overflow mode selectors and the channel/round index width function.
package tdm_accum_pkg;

  localparam int ACC_WRAP = 0;
  localparam int ACC_SAT  = 1;

  // A one-entry counter still needs one bit of storage.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_accum_add.sv
// Accumulator adder: round-0 load or acc+din with wrap/saturate.
// Combinational, no handshake; ovf flags a carry out of DOUT_W bits.
module tdm_accum_add
  import tdm_accum_pkg::*;
#(
  parameter int DIN_W  = 6,
  parameter int DOUT_W = 8,
  parameter int SAT    = ACC_WRAP
) (
  input  logic [DOUT_W-1:0] acc,
  input  logic [DIN_W-1:0]  din,
  input  logic              first,
  output logic [DOUT_W-1:0] sum,
  output logic              ovf
);

  logic [DOUT_W:0] ext_din;
  logic [DOUT_W:0] wide;

  always_comb begin
    ext_din = (DOUT_W+1)'(din);
    wide    = {1'b0, acc} + ext_din;
    sum     = wide[DOUT_W-1:0];
    ovf     = 1'b0;
    if (first) begin
      sum = ext_din[DOUT_W-1:0];
    end else if (wide[DOUT_W]) begin
      ovf = 1'b1;
      if (SAT == ACC_SAT) sum = '1;
    end
  end

endmodule

// File: rtl/tdm_accum.sv
// Per-channel accumulator over LEN rounds of a CH-way interleaved stream.
// Result one cycle after the final-round accept; din_ready drops while a result is stalled.
module tdm_accum
  import tdm_accum_pkg::*;
#(
  parameter int CH     = 4,
  parameter int LEN    = 4,
  parameter int DIN_W  = 6,
  parameter int DOUT_W = 8,
  parameter int SAT    = ACC_WRAP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [DIN_W-1:0]       din,
  output logic [idx_w(CH)-1:0]   ch_idx,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [DOUT_W-1:0]      dout,
  output logic [idx_w(CH)-1:0]   dout_ch,
  output logic                   dout_last,
  output logic                   overflow
);

  localparam int CW = idx_w(CH);
  localparam int RW = idx_w(LEN);

  logic [CW-1:0]     ch_cnt;
  logic [RW-1:0]     rnd_cnt;
  logic [DOUT_W-1:0] acc [CH];

  logic              accept;
  logic              ch_wrap;
  logic              rnd_last;
  logic              first;
  logic [DOUT_W-1:0] sum;
  logic              ovf;

  assign din_ready = !dout_valid || dout_ready;
  // clr wins over a coincident sample, so it never reaches the counters or slots.
  assign accept    = din_valid && din_ready && !clr;
  assign ch_wrap   = (ch_cnt == CW'(CH - 1));
  assign rnd_last  = (rnd_cnt == RW'(LEN - 1));
  assign first     = (rnd_cnt == '0);
  assign ch_idx    = ch_cnt;

  tdm_accum_add #(
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .SAT    (SAT)
  ) u_add (
    .acc   (acc[ch_cnt]),
    .din   (din),
    .first (first),
    .sum   (sum),
    .ovf   (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt  <= '0;
      rnd_cnt <= '0;
    end else if (clr) begin
      ch_cnt  <= '0;
      rnd_cnt <= '0;
    end else if (accept) begin
      ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
      if (ch_wrap) rnd_cnt <= rnd_last ? '0 : rnd_cnt + 1'b1;
    end
  end

  // The final round goes straight to the output register; its slot is reloaded in round 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else if (accept && !rnd_last) begin
      acc[ch_cnt] <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_last  <= 1'b0;
    end else if (clr) begin
      dout_valid <= 1'b0;
    end else if (accept && rnd_last) begin
      dout_valid <= 1'b1;
      dout       <= sum;
      dout_ch    <= ch_cnt;
      dout_last  <= ch_wrap;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (accept && ovf) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: doc/tdm_accum.md
# tdm_accum

Parametrised time-division-multiplexed accumulator: a single input stream carries CH interleaved unsigned channels (channel 0 first, then 1 … CH-1, repeating), and each channel's samples are summed over LEN rounds to form one frame. At frame end, each channel's sum is emitted on a valid/ready output with its channel index. The block generalises the fixed 4-channel/4-sample/6→8-bit accumulator used in the datapath. It adds:
- configurable channel count, frame length and data widths;
- input/output handshakes with backpressure;
- a wrap or saturate overflow mode with a sticky overflow flag.

## Interface
Parameters:
- CH, 4, number of interleaved channels (≥1)
- LEN, 4, samples per channel per frame (≥1)
- DIN_W, 6, input sample width, unsigned
- DOUT_W, 8, accumulator/output width, unsigned; DOUT_W ≥ DIN_W
- SAT, 0, 0 = wrap modulo 2^DOUT_W, 1 = saturate at 2^DOUT_W-1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous frame restart
- din_valid  in  1  input sample valid
- din_ready  out  1  input can be accepted
- din  in  DIN_W  sample for the channel given by ch_idx
- ch_idx  out  max(1,$clog2(CH))  channel the next accepted sample belongs to
- dout_valid  out  1  result valid
- dout_ready  in  1  downstream accepts result
- dout  out  DOUT_W  channel sum
- dout_ch  out  max(1,$clog2(CH))  channel of dout
- dout_last  out  1  dout is channel CH-1 of the frame
- overflow  out  1  sticky: some addition exceeded DOUT_W since reset/clr

## Operation
- Accept = din_valid && din_ready. din_ready = !dout_valid || dout_ready (combinational).
- Counters:
  - ch_cnt runs 0..CH-1 and advances on each accept, wrapping to 0.
  - rnd_cnt runs 0..LEN-1 and advances when ch_cnt wraps, wrapping to 0.
  - ch_idx = ch_cnt.
- Counters hold while no accept occurs; din_valid gaps never reset frame position.
- Accumulator update on accept, with acc[ch_cnt] as the slot (CH × DOUT_W storage):
  - rnd_cnt==0: sum = zero-extended din.
  - Otherwise: sum = acc + din, computed at DOUT_W+1 bits.
- Overflow handling when the carry bit is set:
  - SAT=0: result = low DOUT_W bits.
  - SAT=1: result = all-ones.
  - overflow is set in both modes.
- On an accept with rnd_cnt==LEN-1:
  - sum goes to the output register: dout_valid←1, dout_ch←ch_cnt, dout_last←(ch_cnt==CH-1).
  - The slot is not rewritten.
- LEN==1: every sample passes through as its own result. CH==1: single-channel accumulator, dout_last always 1.
- Output register holds dout/dout_ch/dout_last stable while dout_valid && !dout_ready. It clears dout_valid on dout_ready unless a new result loads in the same cycle.
- clr:
  - counters←0, dout_valid←0, overflow←0.
  - Overrides a simultaneous accept: that sample is discarded and counters do not advance.
  - Accumulator contents are don't-care, since round 0 overwrites them.

## Timing
- Reset values: din_ready 1, ch_idx 0, dout_valid 0, dout 0, dout_ch 0, dout_last 0, overflow 0. All counters and the accumulator reset to 0.
- Latency: dout_valid rises on the clock edge after the final (round LEN-1) accept of that channel.
- Throughput: one sample per cycle while dout_ready is high. A full frame yields CH results on CH consecutive cycles.
- Backpressure: dout_valid && !dout_ready forces din_ready low. No sample is lost or double-counted.
- Simultaneous dout_ready and final-round accept: the old result retires and the new one loads in the same cycle; dout_valid stays 1.
- overflow rises the cycle after the offending accept and stays high until clr or reset.
- Reset mid-frame: all state returns immediately to reset values. The next accept is channel 0, round 0.

## Structure
- Package tdm_accum_pkg holds:
  - the mode constants ACC_WRAP=0 and ACC_SAT=1;
  - the function computing the index width max(1,$clog2(n)).
- Sub-module tdm_accum_add: combinational DOUT_W adder with SAT parameter.
  - Inputs: acc, din, first.
  - Outputs: sum, ovf.
- Top level holds the counters, accumulator array, output register and handshake.

## Test plan
- Defaults, 16 back-to-back samples all =1, dout_ready=1 → dout 4,4,4,4 on dout_ch 0..3 on 4 consecutive cycles; dout_last only on ch 3; overflow=0.
- Defaults, samples 0..15 in order → channel c sums c+(c+4)+(c+8)+(c+12): outputs 24,28,32,36.
- LEN=5, all samples 63 → SAT=0: dout=59 each and overflow=1; SAT=1: dout=255 each and overflow=1.
- dout_ready low for 5 cycles while channel 0 result is pending → dout=4/dout_ch=0 held stable and din_ready=0. Remaining results then arrive in order with none dropped.
- Random din_valid gaps over 2 frames → results identical to gap-free run; ch_idx tracks accepted-sample count mod CH.
- clr asserted at round 2 channel 1 with din_valid=1, then 16 samples of 2 → that sample discarded, counters and overflow cleared, outputs 8,8,8,8. Repeat with rst_n pulse mid-frame → same result after release.
